// File: rtl/memory_sequence_checker.sv
// Memory-game control stage: grows a nibble sequence one entry per round, replays it,
// then checks the player's key entries while tracking level and score.
module memory_sequence_checker #(
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned SHOW_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           start,
  input  logic [3:0]                     pattern_in,
  input  logic                           pattern_valid,
  output logic                           pattern_req,
  input  logic [3:0]                     key_in,
  input  logic                           key_valid,
  output logic [3:0]                     display,
  output logic                           display_on,
  output logic                           input_en,
  output logic                           match_pulse,
  output logic                           round_ok,
  output logic                           fail,
  output logic                           win,
  output logic [$clog2(MAX_LEN+1)-1:0]   level,
  output logic [SCORE_W-1:0]             score
);

  localparam int unsigned LW   = $clog2(MAX_LEN + 1);
  localparam int unsigned IW   = $clog2(MAX_LEN);
  localparam int unsigned PW   = $clog2(SHOW_CYCLES + GAP_CYCLES);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SUMW = ((SCORE_W > LW) ? SCORE_W : LW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_SHOW, S_INPUT, S_ROUND_OK, S_FAIL, S_WIN
  } state_t;

  state_t          state;
  logic [3:0]      seq_mem [MAX_LEN];
  logic [IW-1:0]   idx;
  logic [IW-1:0]   last;
  logic [PW-1:0]   phase;
  logic [TW-1:0]   idle_cnt;
  logic [SUMW-1:0] score_sum;

  always_comb begin
    last      = IW'(level - 1'b1);
    score_sum = SUMW'(score) + SUMW'(level);
  end

  always_ff @(posedge CLK) begin
    if (state == S_APPEND && pattern_valid)
      seq_mem[last] <= pattern_in;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      idx         <= '0;
      phase       <= '0;
      idle_cnt    <= '0;
      pattern_req <= 1'b0;
      display     <= '0;
      display_on  <= 1'b0;
      input_en    <= 1'b0;
      match_pulse <= 1'b0;
      round_ok    <= 1'b0;
      fail        <= 1'b0;
      win         <= 1'b0;
      level       <= '0;
      score       <= '0;
    end else begin
      match_pulse <= 1'b0;
      round_ok    <= 1'b0;
      unique case (state)
        S_IDLE, S_FAIL, S_WIN: begin
          if (start) begin
            state       <= S_APPEND;
            level       <= LW'(1);
            score       <= '0;
            fail        <= 1'b0;
            win         <= 1'b0;
            pattern_req <= 1'b1;
          end
        end
        S_APPEND: begin
          if (pattern_valid) begin
            state       <= S_SHOW;
            pattern_req <= 1'b0;
            idx         <= '0;
            phase       <= '0;
            display_on  <= 1'b1;
            // On the first round the nibble is still being written, so show it directly.
            display     <= (level == LW'(1)) ? pattern_in : seq_mem[IW'(0)];
          end
        end
        S_SHOW: begin
          if (phase == PW'(SHOW_CYCLES + GAP_CYCLES - 1)) begin
            phase <= '0;
            if (idx == last) begin
              state    <= S_INPUT;
              input_en <= 1'b1;
              idx      <= '0;
              idle_cnt <= '0;
            end else begin
              idx        <= idx + 1'b1;
              display_on <= 1'b1;
              display    <= seq_mem[idx + 1'b1];
            end
          end else begin
            phase <= phase + 1'b1;
            if (phase >= PW'(SHOW_CYCLES - 1)) begin
              display_on <= 1'b0;
              display    <= '0;
            end
          end
        end
        S_INPUT: begin
          // A key arriving on the expiry cycle takes priority over the timeout.
          if (key_valid) begin
            if (key_in == seq_mem[idx]) begin
              match_pulse <= 1'b1;
              idle_cnt    <= '0;
              idx         <= idx + 1'b1;
              if (idx == last) begin
                state    <= S_ROUND_OK;
                input_en <= 1'b0;
                round_ok <= 1'b1;
                score    <= (score_sum > SUMW'({SCORE_W{1'b1}})) ? '1 : SCORE_W'(score_sum);
              end
            end else begin
              state    <= S_FAIL;
              input_en <= 1'b0;
              fail     <= 1'b1;
            end
          end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state    <= S_FAIL;
            input_en <= 1'b0;
            fail     <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_ROUND_OK: begin
          if (level == LW'(MAX_LEN)) begin
            state <= S_WIN;
            win   <= 1'b1;
          end else begin
            state       <= S_APPEND;
            level       <= level + 1'b1;
            pattern_req <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
